hw1_comb_sweep_checker: RTL and testbench

Sequential stimulus-and-check engine for the HW1 four-input combinational function. It drives A, B, C and D through all 16 input combinations. For each combination it samples the F outputs of the three implementations (dataflow, gate-level, hf-gate-level) and compares them against a golden truth table or against each other. It reports a pass/fail summary. It sits opposite the HW1_comb_* modules: it produces their inputs and consumes their outputs, so the sweep can run on hardware and not only in a simulation testbench.

---
 rtl/hw1_pkg.sv | 26 ++
 rtl/hw1_comb_sweep_checker.sv | 156 +++++++++++++++
 tb/tb_hw1_comb_sweep_checker.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hw1_pkg.sv
// ============================================================================
//  Module      : hw1_pkg
//  Description : Shared constants, sweep FSM state type and golden truth table
//                for the HW1 four-input combinational sweep checker.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hw1_pkg;

    localparam int N_VEC = 16;
    localparam int VEC_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    // Golden F for input {A,B,C,D}, indexed by the 4-bit vector value.
    localparam logic [N_VEC-1:0] HW1_F_TABLE = 16'hA0F5;

endpackage

`default_nettype wire

// File: rtl/hw1_comb_sweep_checker.sv
// ============================================================================
//  Module      : hw1_comb_sweep_checker
//  Description : Drives A..D through all 16 vectors, samples F1/F2/F3 after a
//                settle delay and accumulates pass/fail statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hw1_comb_sweep_checker
    import hw1_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,       // legal range 1..15
    parameter logic [N_VEC-1:0] EXP_TABLE     = 16'h0000,
    parameter bit               CHECK_GOLDEN  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             A,
    output logic             B,
    output logic             C,
    output logic             D,
    input  logic             F1,
    input  logic             F2,
    input  logic             F3,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [4:0]       err_count,
    output logic [2:0]       err_mask,
    output logic             first_err_valid,
    output logic [VEC_W-1:0] first_err_vec
);

    localparam logic [3:0] c_settle_last = 4'(SETTLE_CYCLES - 1);
    localparam logic [4:0] c_count_max   = 5'(N_VEC);

    sweep_state_t     r_state;
    logic [VEC_W-1:0] r_vec;
    logic [3:0]       r_settle_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic [4:0]       r_err_count;
    logic [2:0]       r_err_mask;
    logic             r_first_err_valid;
    logic [VEC_W-1:0] r_first_err_vec;

    logic             w_exp;
    logic [2:0]       w_err;
    logic             w_err_any;
    logic [4:0]       w_err_count_nxt;

    // Case-inequality so that an undriven or unknown F is flagged in simulation.
    always_comb begin
        w_exp = EXP_TABLE[r_vec];
        w_err = 3'b000;
        if (CHECK_GOLDEN) begin
            w_err[0] = (F1 !== w_exp);
            w_err[1] = (F2 !== w_exp);
            w_err[2] = (F3 !== w_exp);
        end else begin
            w_err[0] = 1'b0;
            w_err[1] = (F2 !== F1);
            w_err[2] = (F3 !== F1);
        end
        w_err_any       = |w_err;
        w_err_count_nxt = r_err_count;
        if (w_err_any && (r_err_count != c_count_max)) begin
            w_err_count_nxt = r_err_count + 5'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state           <= IDLE;
            r_vec             <= '0;
            r_settle_cnt      <= '0;
            r_busy            <= 1'b0;
            r_done            <= 1'b0;
            r_pass            <= 1'b0;
            r_err_count       <= '0;
            r_err_mask        <= '0;
            r_first_err_valid <= 1'b0;
            r_first_err_vec   <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state           <= SETTLE;
                        r_vec             <= '0;
                        r_settle_cnt      <= '0;
                        r_busy            <= 1'b1;
                        r_done            <= 1'b0;
                        r_pass            <= 1'b0;
                        r_err_count       <= '0;
                        r_err_mask        <= '0;
                        r_first_err_valid <= 1'b0;
                        r_first_err_vec   <= '0;
                    end
                end
                SETTLE: begin
                    r_settle_cnt <= r_settle_cnt + 4'd1;
                    if (r_settle_cnt == c_settle_last) begin
                        r_state <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    r_err_count <= w_err_count_nxt;
                    if (w_err_any) begin
                        r_err_mask <= r_err_mask | w_err;
                        if (!r_first_err_valid) begin
                            r_first_err_valid <= 1'b1;
                            r_first_err_vec   <= r_vec;
                        end
                    end
                    // The last vector is held on A..D while results sit in DONE.
                    if (r_vec == 4'hF) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_err_count_nxt == 5'd0);
                    end else begin
                        r_vec        <= r_vec + 4'd1;
                        r_settle_cnt <= '0;
                        r_state      <= SETTLE;
                    end
                end
                default: begin
                    r_state           <= IDLE;
                    r_vec             <= '0;
                    r_settle_cnt      <= '0;
                    r_busy            <= 1'b0;
                    r_done            <= 1'b0;
                    r_pass            <= 1'b0;
                    r_err_count       <= '0;
                    r_err_mask        <= '0;
                    r_first_err_valid <= 1'b0;
                    r_first_err_vec   <= '0;
                end
            endcase
        end
    end

    assign {A, B, C, D}    = r_vec;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_count       = r_err_count;
    assign err_mask        = r_err_mask;
    assign first_err_valid = r_first_err_valid;
    assign first_err_vec   = r_first_err_vec;

endmodule

`default_nettype wire

// File: tb/tb_hw1_comb_sweep_checker.sv
// ============================================================================
//  Module      : tb_hw1_comb_sweep_checker
//  Description : Randomized self-checking bench for hw1_comb_sweep_checker in
//                golden-table mode and in cross-compare mode.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hw1_comb_sweep_checker;
    import hw1_pkg::*;

    localparam int G_SETTLE = 2;
    localparam int R_SETTLE = 3;
    localparam int G_CYCLES = N_VEC * (G_SETTLE + 1);
    localparam int R_CYCLES = N_VEC * (R_SETTLE + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Golden-mode instance (g_*) and cross-compare instance (r_*).
    logic        g_rst_n = 1'b0, g_start = 1'b0;
    logic        g_a, g_b, g_c, g_d, g_f1, g_f2, g_f3;
    logic        g_busy, g_done, g_pass, g_fev;
    logic [4:0]  g_cnt;
    logic [2:0]  g_mask;
    logic [3:0]  g_fvec;
    logic [15:0] g_t1 = '0, g_t2 = '0, g_t3 = '0;

    logic        r_rst_n = 1'b0, r_start = 1'b0;
    logic        r_a, r_b, r_c, r_d, r_f1, r_f2, r_f3;
    logic        r_busy, r_done, r_pass, r_fev;
    logic [4:0]  r_cnt;
    logic [2:0]  r_mask;
    logic [3:0]  r_fvec;
    logic [15:0] r_t1 = '0, r_t2 = '0, r_t3 = '0;

    wire [3:0]  g_vec = {g_a, g_b, g_c, g_d};
    wire [3:0]  r_vec = {r_a, r_b, r_c, r_d};
    // Implementations under test are modelled by their truth tables.
    assign g_f1 = g_t1[g_vec];
    assign g_f2 = g_t2[g_vec];
    assign g_f3 = g_t3[g_vec];
    assign r_f1 = r_t1[r_vec];
    assign r_f2 = r_t2[r_vec];
    assign r_f3 = r_t3[r_vec];

    wire [19:0] g_res = {g_done, g_busy, g_pass, g_cnt, g_mask, g_fev, g_fvec, g_vec};
    wire [19:0] r_res = {r_done, r_busy, r_pass, r_cnt, r_mask, r_fev, r_fvec, r_vec};
    localparam logic [19:0] c_just_started = {1'b0, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0, 4'd0, 4'd0};

    hw1_comb_sweep_checker #(
        .SETTLE_CYCLES (G_SETTLE),
        .EXP_TABLE     (HW1_F_TABLE),
        .CHECK_GOLDEN  (1'b1)
    ) u_gold (
        .clk (clk), .rst_n (g_rst_n), .start (g_start),
        .A (g_a), .B (g_b), .C (g_c), .D (g_d),
        .F1 (g_f1), .F2 (g_f2), .F3 (g_f3),
        .busy (g_busy), .done (g_done), .pass (g_pass),
        .err_count (g_cnt), .err_mask (g_mask),
        .first_err_valid (g_fev), .first_err_vec (g_fvec)
    );

    hw1_comb_sweep_checker #(
        .SETTLE_CYCLES (R_SETTLE),
        .EXP_TABLE     (16'h0000),
        .CHECK_GOLDEN  (1'b0)
    ) u_rel (
        .clk (clk), .rst_n (r_rst_n), .start (r_start),
        .A (r_a), .B (r_b), .C (r_c), .D (r_d),
        .F1 (r_f1), .F2 (r_f2), .F3 (r_f3),
        .busy (r_busy), .done (r_done), .pass (r_pass),
        .err_count (r_cnt), .err_mask (r_mask),
        .first_err_valid (r_fev), .first_err_vec (r_fvec)
    );

    // Expected final outputs of a full sweep, from the truth tables alone.
    function automatic logic [19:0] model(input logic [15:0] exp_tbl, input bit golden,
                                          input logic [15:0] t1, input logic [15:0] t2,
                                          input logic [15:0] t3);
        int         n_fail = 0;
        logic [2:0] mask   = 3'b000;
        logic [2:0] e;
        bit         seen   = 1'b0;
        logic [3:0] first  = 4'd0;
        for (int v = 0; v < N_VEC; v++) begin
            if (golden) e = {t3[v] != exp_tbl[v], t2[v] != exp_tbl[v], t1[v] != exp_tbl[v]};
            else        e = {t3[v] != t1[v], t2[v] != t1[v], 1'b0};
            if (e != 3'b000) begin
                n_fail++;
                mask = mask | e;
                if (!seen) begin
                    seen  = 1'b1;
                    first = 4'(v);
                end
            end
        end
        return {1'b1, 1'b0, n_fail == 0, 5'(n_fail), mask, seen, first, 4'hF};
    endfunction

    // Pulses start, optionally re-pulses it mid-sweep, and reports the cycle
    // (counted from the start edge) at which done is first seen.
    task automatic sweep(input bit rel, input int extra_start_at,
                         output int cycles, output logic [19:0] snap0);
        @(negedge clk);
        if (rel) r_start = 1'b1; else g_start = 1'b1;
        @(negedge clk);
        r_start = 1'b0;
        g_start = 1'b0;
        snap0   = rel ? r_res : g_res;
        cycles  = -1;
        for (int c = 1; c <= 400; c++) begin
            @(negedge clk);
            if (rel) r_start = (c == extra_start_at);
            else     g_start = (c == extra_start_at);
            if (rel ? r_done : g_done) begin
                cycles = c;
                break;
            end
        end
        r_start = 1'b0;
        g_start = 1'b0;
    endtask

    task automatic test_reset();
        g_rst_n = 1'b0;
        r_rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (g_res !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_gold: got %h want %h", g_res, 20'h0);
        end
        n_cmp++;
        if (r_res !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_rel: got %h want %h", r_res, 20'h0);
        end
        g_rst_n = 1'b1;
        r_rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (g_res !== 20'h0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %h want %h", g_res, 20'h0);
        end
    endtask

    task automatic test_golden(input string name, input logic [15:0] f1,
                               input logic [15:0] f2, input logic [15:0] f3,
                               input int extra_start_at);
        int          cyc;
        logic [19:0] snap, exp_res;
        g_t1 = f1;
        g_t2 = f2;
        g_t3 = f3;
        exp_res = model(HW1_F_TABLE, 1'b1, f1, f2, f3);
        sweep(1'b0, extra_start_at, cyc, snap);
        n_cmp++;
        if (snap !== c_just_started) begin
            n_bad++;
            $display("FAIL %s start_state: got %h want %h", name, snap, c_just_started);
        end
        n_cmp++;
        if (cyc != G_CYCLES) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, G_CYCLES);
        end
        n_cmp++;
        if (g_res !== exp_res) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, g_res, exp_res);
        end
    endtask

    task automatic test_relative(input string name, input logic [15:0] f1,
                                 input logic [15:0] f2, input logic [15:0] f3);
        int          cyc;
        logic [19:0] snap, exp_res;
        r_t1 = f1;
        r_t2 = f2;
        r_t3 = f3;
        exp_res = model(16'h0000, 1'b0, f1, f2, f3);
        sweep(1'b1, -1, cyc, snap);
        n_cmp++;
        if (snap !== c_just_started) begin
            n_bad++;
            $display("FAIL %s start_state: got %h want %h", name, snap, c_just_started);
        end
        n_cmp++;
        if (cyc != R_CYCLES) begin
            n_bad++;
            $display("FAIL %s done_cycle: got %0d want %0d", name, cyc, R_CYCLES);
        end
        n_cmp++;
        if (r_res !== exp_res) begin
            n_bad++;
            $display("FAIL %s result: got %h want %h", name, r_res, exp_res);
        end
    endtask

    task automatic test_reset_mid_sweep();
        g_t1 = HW1_F_TABLE;
        g_t2 = ~HW1_F_TABLE;
        g_t3 = HW1_F_TABLE;
        @(negedge clk);
        g_start = 1'b1;
        @(negedge clk);
        g_start = 1'b0;
        repeat (24) @(negedge clk);
        #2;
        g_rst_n = 1'b0;
        #1;
        n_cmp++;
        if (g_res !== 20'h0) begin
            n_bad++;
            $display("FAIL reset_mid_sweep: got %h want %h", g_res, 20'h0);
        end
        @(negedge clk);
        g_start = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (g_res !== 20'h0) begin
            n_bad++;
            $display("FAIL start_during_reset: got %h want %h", g_res, 20'h0);
        end
        g_start = 1'b0;
        g_rst_n = 1'b1;
        test_golden("after_reset_good", HW1_F_TABLE, HW1_F_TABLE, HW1_F_TABLE, -1);
    endtask

    task automatic test_random_golden(input int iters);
        logic [15:0] m1, m2, m3;
        for (int i = 0; i < iters; i++) begin
            m1 = 16'($urandom & $urandom & $urandom);
            m2 = 16'($urandom & $urandom);
            m3 = 16'($urandom & $urandom & $urandom);
            test_golden("random_golden", HW1_F_TABLE ^ m1, HW1_F_TABLE ^ m2,
                        HW1_F_TABLE ^ m3, -1);
        end
    endtask

    task automatic test_random_relative(input int iters);
        logic [15:0] base;
        for (int i = 0; i < iters; i++) begin
            base = 16'($urandom);
            test_relative("random_relative", base, base ^ 16'($urandom & $urandom),
                          base ^ 16'($urandom & $urandom & $urandom));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] base;
        test_reset();
        test_golden("all_good", HW1_F_TABLE, HW1_F_TABLE, HW1_F_TABLE, -1);
        test_golden("f2_stuck0", HW1_F_TABLE, 16'h0000, HW1_F_TABLE, -1);
        test_golden("restart_clears", HW1_F_TABLE, HW1_F_TABLE, HW1_F_TABLE, -1);
        test_golden("start_ignored", HW1_F_TABLE, HW1_F_TABLE, HW1_F_TABLE, 20);
        test_golden("all_f_wrong", ~HW1_F_TABLE, ~HW1_F_TABLE, ~HW1_F_TABLE, -1);
        test_golden("last_vec_only", HW1_F_TABLE, HW1_F_TABLE, HW1_F_TABLE ^ 16'h8000, -1);
        test_reset_mid_sweep();
        test_random_golden(5);
        base = 16'($urandom);
        test_relative("f3_inverted", base, base, ~base);
        test_relative("rel_all_agree", base, base, base);
        test_relative("f1_differs", base ^ 16'h0010, base, base);
        test_random_relative(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
